// File: rtl/assert_seq_gen.sv
// assert_seq_gen: driving end of the st/a/b/c/d value-change protocol.
// On a go request it plays one sequence, either legal or carrying exactly one
// selected fault. The sequence is checked against
// $rose(st) |-> $rose(a) ##1 $stable(b&c) ##1 $fell(d).
// It then idles for GAP_CYCLES all-zero cycles and pulses done.
// Optional macro SEQ_FAULT_CNT_EN adds the fault_cnt output, which counts
// completed sequences that were run with a non-zero mode.
module assert_seq_gen #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [1:0]       mode,
  input  logic [1:0]       bc_init,
  output logic             st,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] seq_cnt
`ifdef SEQ_FAULT_CNT_EN
  ,
  output logic [CNT_W-1:0] fault_cnt
`endif
);

  // Fault selection encoding of the mode input.
  localparam logic [1:0] MODE_LEGAL  = 2'd0;
  localparam logic [1:0] MODE_BRK_BC = 2'd1;
  localparam logic [1:0] MODE_BRK_D  = 2'd2;
  localparam logic [1:0] MODE_BRK_A  = 2'd3;

  // Index of the last idle cycle in GAP (unused when GAP_CYCLES is 0).
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 32'd0) ? 4'd0 : 4'(GAP_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_START = 3'd2,
    S_HOLD  = 3'd3,
    S_FALL  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t     r_state;
  logic [1:0] r_mode;     // mode captured at acceptance
  logic [1:0] r_bc;       // {b,c} captured at acceptance
  logic [3:0] r_gap_cnt;  // idle cycles already spent in GAP
  logic       w_seq_end;  // current cycle is the last busy one

  // Decide whether the next edge returns the FSM to IDLE.
  always_comb begin
    w_seq_end = 1'b0;
    if (r_state == S_FALL) begin
      w_seq_end = (GAP_CYCLES == 32'd0);
    end else if (r_state == S_GAP) begin
      w_seq_end = (r_gap_cnt == GAP_LAST);
    end else begin
      w_seq_end = 1'b0;
    end
  end

  // Sequence FSM with all protocol and status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= 2'd0;
      r_bc      <= 2'd0;
      r_gap_cnt <= 4'd0;
      st        <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      d         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seq_cnt   <= '0;
`ifdef SEQ_FAULT_CNT_EN
      fault_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          st <= 1'b0;
          a  <= 1'b0;
          d  <= 1'b0;
          if (go) begin
            // Accept: capture the request and show bc_init in PRE.
            r_mode  <= mode;
            r_bc    <= bc_init;
            b       <= bc_init[1];
            c       <= bc_init[0];
            busy    <= 1'b1;
            r_state <= S_PRE;
          end else begin
            b       <= 1'b0;
            c       <= 1'b0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_PRE: begin
          // st and a were 0 in PRE, so this edge is a rise unless a is broken.
          st      <= 1'b1;
          a       <= (r_mode != MODE_BRK_A);
          b       <= r_bc[1];
          c       <= r_bc[0];
          d       <= 1'b0;
          busy    <= 1'b1;
          r_state <= S_START;
        end

        S_START: begin
          st   <= 1'b0;
          a    <= 1'b0;
          d    <= 1'b1;
          busy <= 1'b1;
          if (r_mode == MODE_BRK_BC) begin
            // Flip b&c: 1 -> 0 by clearing b, 0 -> 1 by setting both.
            if (r_bc[1] & r_bc[0]) begin
              b <= 1'b0;
              c <= r_bc[0];
            end else begin
              b <= 1'b1;
              c <= 1'b1;
            end
          end else begin
            b <= r_bc[1];
            c <= r_bc[0];
          end
          r_state <= S_HOLD;
        end

        S_HOLD: begin
          st      <= 1'b0;
          a       <= 1'b0;
          b       <= 1'b0;
          c       <= 1'b0;
          d       <= (r_mode == MODE_BRK_D);
          busy    <= 1'b1;
          r_state <= S_FALL;
        end

        S_FALL, S_GAP: begin
          st <= 1'b0;
          a  <= 1'b0;
          b  <= 1'b0;
          c  <= 1'b0;
          d  <= 1'b0;
          if (w_seq_end) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            seq_cnt <= seq_cnt + CNT_ONE;
`ifdef SEQ_FAULT_CNT_EN
            if (r_mode != MODE_LEGAL) begin
              fault_cnt <= fault_cnt + CNT_ONE;
            end else begin
              fault_cnt <= fault_cnt;
            end
`endif
            r_gap_cnt <= 4'd0;
            r_state   <= S_IDLE;
          end else begin
            busy      <= 1'b1;
            r_gap_cnt <= (r_state == S_FALL) ? 4'd0 : (r_gap_cnt + 4'd1);
            r_state   <= S_GAP;
          end
        end

        default: begin
          st        <= 1'b0;
          a         <= 1'b0;
          b         <= 1'b0;
          c         <= 1'b0;
          d         <= 1'b0;
          busy      <= 1'b0;
          r_gap_cnt <= 4'd0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assert_seq_gen.sv
// Self-checking bench for assert_seq_gen: two instances (GAP=1/CNT_W=8 and
// GAP=0/CNT_W=2) driven with directed and random sequences, checked against a
// per-cycle timeline model, an evaluation of the protocol property on the
// observed waveform, and modular sequence counters.
module tb_assert_seq_gen;

  localparam int GAP_X = 1;
  localparam int CNT_X = 8;
  localparam int GAP_Y = 0;
  localparam int CNT_Y = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go_x = 1'b0, go_y = 1'b0;
  logic [1:0] mode_x = 2'd0, bc_x = 2'd0, mode_y = 2'd0, bc_y = 2'd0;
  logic st_x, a_x, b_x, c_x, d_x, busy_x, done_x;
  logic st_y, a_y, b_y, c_y, d_y, busy_y, done_y;
  logic [CNT_X-1:0] cnt_x;
  logic [CNT_Y-1:0] cnt_y;
`ifdef SEQ_FAULT_CNT_EN
  logic [CNT_X-1:0] flt_x;
  logic [CNT_Y-1:0] flt_y;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt [2];
  int exp_flt [2];

  always #5 clk = ~clk;

  assert_seq_gen #(.GAP_CYCLES(GAP_X), .CNT_W(CNT_X)) dut_x (
    .clk(clk), .rst_n(rst_n), .go(go_x), .mode(mode_x), .bc_init(bc_x),
    .st(st_x), .a(a_x), .b(b_x), .c(c_x), .d(d_x),
    .busy(busy_x), .done(done_x), .seq_cnt(cnt_x)
`ifdef SEQ_FAULT_CNT_EN
    , .fault_cnt(flt_x)
`endif
  );

  assert_seq_gen #(.GAP_CYCLES(GAP_Y), .CNT_W(CNT_Y)) dut_y (
    .clk(clk), .rst_n(rst_n), .go(go_y), .mode(mode_y), .bc_init(bc_y),
    .st(st_y), .a(a_y), .b(b_y), .c(c_y), .d(d_y),
    .busy(busy_y), .done(done_y), .seq_cnt(cnt_y)
`ifdef SEQ_FAULT_CNT_EN
    , .fault_cnt(flt_y)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {st,a,b,c,d,busy,done}
  function automatic logic [6:0] obs_vec(input int sel);
    return (sel == 1) ? {st_y, a_y, b_y, c_y, d_y, busy_y, done_y}
                      : {st_x, a_x, b_x, c_x, d_x, busy_x, done_x};
  endfunction

  function automatic logic [31:0] obs_cnt(input int sel);
    return (sel == 1) ? 32'(cnt_y) : 32'(cnt_x);
  endfunction

`ifdef SEQ_FAULT_CNT_EN
  function automatic logic [31:0] obs_flt(input int sel);
    return (sel == 1) ? 32'(flt_y) : 32'(flt_x);
  endfunction
`endif

  task automatic drive(input int sel, input logic g, input logic [1:0] m, input logic [1:0] bc);
    if (sel == 1) begin
      go_y = g; mode_y = m; bc_y = bc;
    end else begin
      go_x = g; mode_x = m; bc_x = bc;
    end
  endtask

  // Idle cycles: both instances quiet, counters unchanged.
  task automatic idle(input int n);
    drive(0, 1'b0, 2'(($urandom)), 2'(($urandom)));
    drive(1, 1'b0, 2'(($urandom)), 2'(($urandom)));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_x", 32'(obs_vec(0)), 32'd0);
      check("idle_y", 32'(obs_vec(1)), 32'd0);
      check("idle_cnt_x", obs_cnt(0), 32'(exp_cnt[0]));
      check("idle_cnt_y", obs_cnt(1), 32'(exp_cnt[1]));
    end
  endtask

  // Plays one sequence; caller guarantees the DUT is in IDLE this cycle.
  // Returns with go low so that a following call runs back-to-back.
  task automatic run_seq(input int sel, input logic [1:0] m, input logic [1:0] bc);
    int gap;
    int last;
    int cw;
    logic [6:0] o;
    logic [6:0] e;
    logic [3:0] h_st, h_a, h_bc, h_d;
    logic [1:0] bc_hold;
    logic pass;
    gap  = (sel == 1) ? GAP_Y : GAP_X;
    cw   = (sel == 1) ? CNT_Y : CNT_X;
    last = 4 + gap;
    h_st = 4'd0; h_a = 4'd0; h_bc = 4'd0; h_d = 4'd0;
    drive(sel, 1'b1, m, bc);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      o = obs_vec(sel);
      // Timeline from the protocol description: PRE, START, HOLD, FALL, GAP.., done.
      if (k == 0)      e = {1'b0, 1'b0, bc, 1'b0, 1'b1, 1'b0};
      else if (k == 1) e = {1'b1, (m != 2'd3), bc, 1'b0, 1'b1, 1'b0};
      else if (k == 2) begin
        bc_hold = (m == 2'd1) ? ((bc == 2'b11) ? 2'b01 : 2'b11) : bc;
        e = {1'b0, 1'b0, bc_hold, 1'b1, 1'b1, 1'b0};
      end
      else if (k == 3) e = {1'b0, 1'b0, 2'b00, (m == 2'd2), 1'b1, 1'b0};
      else if (k < last) e = 7'b0000010;
      else e = 7'b0000001;
      check($sformatf("seq%0d_m%0d_bc%0d_k%0d", sel, m, bc, k), 32'(o), 32'(e));
      if (k < 4) begin
        h_st[k] = o[6]; h_a[k] = o[5]; h_bc[k] = o[4] & o[3]; h_d[k] = o[2];
      end
      if (k == last) begin
        exp_cnt[sel] = (exp_cnt[sel] + 1) % (1 << cw);
        if (m != 2'd0) exp_flt[sel] = (exp_flt[sel] + 1) % (1 << cw);
        check($sformatf("seq_cnt%0d", sel), obs_cnt(sel), 32'(exp_cnt[sel]));
`ifdef SEQ_FAULT_CNT_EN
        check($sformatf("fault_cnt%0d", sel), obs_flt(sel), 32'(exp_flt[sel]));
`endif
        drive(sel, 1'b0, 2'(($urandom)), 2'(($urandom)));
      end else begin
        // Inputs change while busy: go pulses and mode/bc churn must be ignored.
        drive(sel, 1'($urandom), 2'(($urandom)), 2'(($urandom)));
      end
    end
    // Evaluate $rose(st) |-> $rose(a) ##1 $stable(b&c) ##1 $fell(d) on what was seen.
    pass = !(h_st[1] && !h_st[0]) ||
           (h_a[1] && !h_a[0] && (h_bc[2] == h_bc[1]) && h_d[2] && !h_d[3]);
    check($sformatf("prop%0d_m%0d", sel, m), 32'(pass), 32'(m == 2'd0));
  endtask

  initial begin
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_flt[0] = 0; exp_flt[1] = 0;

    // Reset state.
    #12;
    check("rst_x", 32'(obs_vec(0)), 32'd0);
    check("rst_y", 32'(obs_vec(1)), 32'd0);
    check("rst_cnt_x", obs_cnt(0), 32'd0);
    check("rst_cnt_y", obs_cnt(1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Legal sequence, then single faults.
    run_seq(0, 2'd0, 2'b11);
    idle(1);
    run_seq(0, 2'd1, 2'b11);
    idle(1);
    run_seq(0, 2'd1, 2'b00);
    idle(2);

    // Back-to-back: d fault then a fault, go re-asserted in the done cycle.
    run_seq(0, 2'd2, 2'b10);
    run_seq(0, 2'd3, 2'b11);
    idle(1);

    // Asynchronous reset in HOLD.
    drive(0, 1'b1, 2'd0, 2'b11);
    @(negedge clk);
    drive(0, 1'b0, 2'd0, 2'b11);
    @(negedge clk);
    @(negedge clk);
    check("hold_d", 32'(d_x), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", 32'(obs_vec(0)), 32'd0);
    check("arst_cnt_x", obs_cnt(0), 32'd0);
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_flt[0] = 0; exp_flt[1] = 0;
    @(negedge clk);
    check("arst_hold_x", 32'(obs_vec(0)), 32'd0);
    rst_n = 1'b1;
    idle(3);
    run_seq(0, 2'd0, 2'b11);
    idle(1);

    // Narrow counter with no gap: counts 1,2,3,0, then back-to-back.
    for (int i = 0; i < 4; i++) begin
      run_seq(1, 2'd0, 2'(($urandom)));
      idle(1);
    end
    check("wrap_y", obs_cnt(1), 32'd0);
    run_seq(1, 2'd0, 2'b11);
    run_seq(1, 2'd0, 2'b01);
    idle(1);

    // Randomized sequences on both instances.
    for (int i = 0; i < 24; i++) begin
      run_seq(int'($urandom_range(0, 1)), 2'(($urandom)), 2'(($urandom)));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
